// File: rtl/store_sequence_checker_if.sv
// Processor data-memory store bus as seen by the store sequence checker.
interface store_sequence_checker_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              write_enable;
    logic [ADDR_W-1:0] address_to_mem;
    logic [DATA_W-1:0] data_to_mem;

    modport master (output write_enable, output address_to_mem, output data_to_mem);
    modport slave  (input  write_enable, input  address_to_mem, input  data_to_mem);
endinterface

// File: rtl/store_sequence_checker.sv
// Compares observed stores, in order, against a programmed table of expected
// (address, data) pairs; reports pass/fail/timeout and the first mismatch.
module store_sequence_checker #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 250,
    parameter bit          STRICT  = 1'b1,
    parameter logic [ADDR_W-1:0] WIN_LO = '0,
    parameter logic [ADDR_W-1:0] WIN_HI = ADDR_W'('hFC),
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 cfg_count_we,
    input  logic [IDX_W:0]       cfg_count,
    input  logic                 start,
    store_sequence_checker_if.slave mem_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timed_out,
    output logic [IDX_W:0]       match_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [IDX_W-1:0]     err_index,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [DATA_W-1:0]    err_data
);
    localparam int unsigned CW = IDX_W + 1;
    localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CYC  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WIN_SPAN  = WIN_HI - WIN_LO;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     match_count_q, match_count_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              timed_out_q, timed_out_d;
    logic [IDX_W-1:0]  err_index_q, err_index_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;

    logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
    logic [DATA_W-1:0] tbl_data_q [DEPTH];

    logic              tbl_we;
    logic [ADDR_W-1:0] win_off;
    logic              checked;
    logic              hit;
    logic [CW-1:0]     match_inc;

    // Offset-from-WIN_LO test covers both bounds with one unsigned compare.
    assign win_off   = mem_bus.address_to_mem - WIN_LO;
    assign checked   = mem_bus.write_enable && (STRICT || (win_off <= WIN_SPAN));
    assign hit       = (mem_bus.address_to_mem == tbl_addr_q[match_count_q[IDX_W-1:0]]) &&
                       (mem_bus.data_to_mem    == tbl_data_q[match_count_q[IDX_W-1:0]]);
    assign match_inc = match_count_q + CW'(1);
    assign tbl_we    = cfg_we && (state_q == S_IDLE);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        match_count_d = match_count_q;
        cycle_count_d = cycle_count_q;
        timed_out_d   = timed_out_q;
        err_index_d   = err_index_q;
        err_addr_d    = err_addr_q;
        err_data_d    = err_data_q;

        if (start && (state_q != S_RUN)) begin
            match_count_d = '0;
            cycle_count_d = '0;
            timed_out_d   = 1'b0;
            err_index_d   = '0;
            err_addr_d    = '0;
            err_data_d    = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_count_we)
                    count_d = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
                if (start)
                    state_d = (count_q == '0) ? S_PASS : S_RUN;
            end
            S_RUN: begin
                if (cycle_count_q != '1)
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                if (checked && hit)
                    match_count_d = match_inc;
                if (checked && !hit) begin
                    state_d     = S_FAIL;
                    err_index_d = match_count_q[IDX_W-1:0];
                    err_addr_d  = mem_bus.address_to_mem;
                    err_data_d  = mem_bus.data_to_mem;
                end else if (checked && (match_inc == count_q)) begin
                    state_d = S_PASS;
                end else if (cycle_count_q == LAST_CYC) begin
                    state_d     = S_FAIL;
                    timed_out_d = 1'b1;
                    err_index_d = match_count_d[IDX_W-1:0];
                end
            end
            S_PASS, S_FAIL: begin
                if (start)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            match_count_q <= '0;
            cycle_count_q <= '0;
            timed_out_q   <= 1'b0;
            err_index_q   <= '0;
            err_addr_q    <= '0;
            err_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            match_count_q <= match_count_d;
            cycle_count_q <= cycle_count_d;
            timed_out_q   <= timed_out_d;
            err_index_q   <= err_index_d;
            err_addr_q    <= err_addr_d;
            err_data_q    <= err_data_d;
        end
    end

    // Expected-store table: deliberately not reset, count=0 masks it.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_addr_q[cfg_idx] <= cfg_addr;
            tbl_data_q[cfg_idx] <= cfg_data;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timed_out   = timed_out_q;
    assign match_count = match_count_q;
    assign cycle_count = cycle_count_q;
    assign err_index   = err_index_q;
    assign err_addr    = err_addr_q;
    assign err_data    = err_data_q;
endmodule

// File: tb/tb_store_sequence_checker.sv
// Directed bench: three checker instances (strict/default, TIMEOUT=20, windowed)
// watch one shared store bus and configuration port.
module tb_store_sequence_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_count_we = 1'b0;
    logic [4:0]  cfg_count = '0;
    logic        start = 1'b0;

    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic        fail [3];
    logic        tmo  [3];
    logic [4:0]  mc   [3];
    logic [15:0] cc   [3];
    logic [3:0]  eidx [3];
    logic [31:0] eadr [3];
    logic [31:0] edat [3];

    int n_tests = 0;
    int n_fail  = 0;

    localparam int A = 0;  // STRICT=1, TIMEOUT=250
    localparam int T = 1;  // STRICT=1, TIMEOUT=20
    localparam int W = 2;  // STRICT=0, window 0x00..0xFC

    store_sequence_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    always #5 clk = ~clk;

    store_sequence_checker #(.TIMEOUT(250), .STRICT(1'b1)) u_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count_we(cfg_count_we), .cfg_count(cfg_count), .start(start),
        .mem_bus(bus_if), .busy(busy[A]), .done(done[A]), .pass(pass[A]), .fail(fail[A]),
        .timed_out(tmo[A]), .match_count(mc[A]), .cycle_count(cc[A]), .err_index(eidx[A]),
        .err_addr(eadr[A]), .err_data(edat[A]));

    store_sequence_checker #(.TIMEOUT(20), .STRICT(1'b1)) u_t (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count_we(cfg_count_we), .cfg_count(cfg_count), .start(start),
        .mem_bus(bus_if), .busy(busy[T]), .done(done[T]), .pass(pass[T]), .fail(fail[T]),
        .timed_out(tmo[T]), .match_count(mc[T]), .cycle_count(cc[T]), .err_index(eidx[T]),
        .err_addr(eadr[T]), .err_data(edat[T]));

    store_sequence_checker #(.TIMEOUT(250), .STRICT(1'b0), .WIN_LO(32'h0), .WIN_HI(32'hFC)) u_w (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count_we(cfg_count_we), .cfg_count(cfg_count), .start(start),
        .mem_bus(bus_if), .busy(busy[W]), .done(done[W]), .pass(pass[W]), .fail(fail[W]),
        .timed_out(tmo[W]), .match_count(mc[W]), .cycle_count(cc[W]), .err_index(eidx[W]),
        .err_addr(eadr[W]), .err_data(edat[W]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start just after a rising edge and return just after one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic cfg_entry(input logic [3:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_cnt(input logic [4:0] n);
        cfg_count_we = 1'b1; cfg_count = n;
        tick(1);
        cfg_count_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.write_enable = 1'b1; bus_if.address_to_mem = a; bus_if.data_to_mem = d;
        tick(1);
        bus_if.write_enable = 1'b0;
    endtask

    task automatic load_abc();
        cfg_entry(4'd0, 32'h10, 32'hA);
        cfg_entry(4'd1, 32'h14, 32'hB);
        cfg_entry(4'd2, 32'h18, 32'hC);
        cfg_cnt(5'd3);
    endtask

    initial begin
        bus_if.write_enable = 1'b0;
        bus_if.address_to_mem = '0;
        bus_if.data_to_mem = '0;

        // Reset state
        do_reset();
        check("rst_busy", busy[A], 0);
        check("rst_done", done[A], 0);
        check("rst_match", mc[A], 0);
        check("rst_cycle", cc[A], 0);
        check("rst_err_addr", eadr[A], 0);

        // 1: in-order matching stores with gaps; start during RUN ignored
        load_abc();
        pulse_start();
        check("t1_busy", busy[A], 1);
        store(32'h10, 32'hA);
        tick(2);
        check("t1_match1", mc[A], 1);
        pulse_start();
        check("t1_start_in_run_match", mc[A], 1);
        check("t1_start_in_run_busy", busy[A], 1);
        store(32'h14, 32'hB);
        tick(1);
        check("t1_not_done_yet", done[A], 0);
        store(32'h18, 32'hC);
        check("t1_pass", pass[A], 1);
        check("t1_fail", fail[A], 0);
        check("t1_match3", mc[A], 3);
        check("t1_cycle", cc[A], 7);
        check("t1_w_pass", pass[W], 1);
        tick(3);
        check("t1_cycle_hold", cc[A], 7);

        // 2: data mismatch on 2nd store
        do_reset();
        load_abc();
        pulse_start();
        store(32'h10, 32'hA);
        store(32'h14, 32'hBB);
        check("t2_fail", fail[A], 1);
        check("t2_err_index", eidx[A], 1);
        check("t2_err_addr", eadr[A], 32'h14);
        check("t2_err_data", edat[A], 32'hBB);
        check("t2_timed_out", tmo[A], 0);
        check("t2_match", mc[A], 1);
        store(32'h18, 32'hC);
        store(32'h14, 32'hB);
        check("t2_hold_fail", fail[A], 1);
        check("t2_hold_match", mc[A], 1);
        check("t2_hold_err_data", edat[A], 32'hBB);

        // 3: timeout with TIMEOUT=20, then final store landing on cycle 19
        do_reset();
        cfg_entry(4'd0, 32'h10, 32'hA);
        cfg_entry(4'd1, 32'h14, 32'hB);
        cfg_cnt(5'd2);
        pulse_start();
        store(32'h10, 32'hA);
        tick(18);
        check("t3_cycle19", cc[T], 19);
        check("t3_not_failed_yet", fail[T], 0);
        tick(1);
        check("t3_fail", fail[T], 1);
        check("t3_timed_out", tmo[T], 1);
        check("t3_match", mc[T], 1);
        check("t3_err_index", eidx[T], 1);
        check("t3_err_addr", eadr[T], 0);
        pulse_start();
        check("t3b_restart_tmo_clr", tmo[T], 0);
        check("t3b_restart_match_clr", mc[T], 0);
        store(32'h10, 32'hA);
        tick(18);
        store(32'h14, 32'hB);
        check("t3b_pass", pass[T], 1);
        check("t3b_timed_out", tmo[T], 0);

        // 4: out-of-window store ignored when STRICT=0, fatal when STRICT=1
        do_reset();
        load_abc();
        pulse_start();
        store(32'h10, 32'hA);
        store(32'h200, 32'h55);
        store(32'h14, 32'hB);
        store(32'h18, 32'hC);
        check("t4_w_pass", pass[W], 1);
        check("t4_w_match", mc[W], 3);
        check("t4_a_fail", fail[A], 1);
        check("t4_a_err_addr", eadr[A], 32'h200);
        check("t4_a_err_data", edat[A], 32'h55);
        check("t4_a_err_index", eidx[A], 1);

        // 5: empty table passes at once; cfg_we during RUN ignored
        do_reset();
        pulse_start();
        check("t5_empty_pass", pass[A], 1);
        do_reset();
        load_abc();
        pulse_start();
        cfg_entry(4'd1, 32'h14, 32'hDD);
        store(32'h10, 32'hA);
        store(32'h14, 32'hB);
        store(32'h18, 32'hC);
        check("t5_run1_pass", pass[A], 1);
        pulse_start();
        check("t5_rerun_busy", busy[A], 1);
        check("t5_rerun_match_clr", mc[A], 0);
        store(32'h10, 32'hA);
        store(32'h14, 32'hB);
        store(32'h18, 32'hC);
        check("t5_run2_pass", pass[A], 1);

        // 6: reset mid-RUN clears state and count
        do_reset();
        load_abc();
        pulse_start();
        store(32'h10, 32'hA);
        check("t6_match1", mc[A], 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_busy", busy[A], 0);
        check("t6_match", mc[A], 0);
        check("t6_cycle", cc[A], 0);
        pulse_start();
        check("t6_count0_pass", pass[A], 1);

        // Oversized count clamps to DEPTH=16
        do_reset();
        for (int i = 0; i < 16; i++)
            cfg_entry(4'(i), 32'(4 * i), 32'(i + 1));
        cfg_cnt(5'd31);
        pulse_start();
        for (int i = 0; i < 15; i++)
            store(32'(4 * i), 32'(i + 1));
        check("clamp_busy_at15", busy[A], 1);
        store(32'(60), 32'(16));
        check("clamp_pass", pass[A], 1);
        check("clamp_match", mc[A], 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/store_sequence_checker.md
Name: store_sequence_checker

Overview:
- Synthesizable, parametrised checker that monitors the processor's data-memory store bus (address_to_mem, data_to_mem, write_enable).
- Compares each observed store, in order, against a programmable table of expected (address, data) pairs.
- Raises a pass/fail verdict, a timeout after a configurable cycle budget, and diagnostics for the first mismatch.
- Sits beside top on the same clock and lets self-checking runs (in simulation or on FPGA) end without dumping and diffing memory.

Parameters:
- ADDR_W, 32, width of address_to_mem and table addresses
- DATA_W, 32, width of data_to_mem and table data
- DEPTH, 16, maximum expected stores (power of two, >=2); IDX_W = clog2(DEPTH)
- CNT_W, 16, width of cycle_count; TIMEOUT must be < 2^CNT_W
- TIMEOUT, 250, RUN cycles allowed before timeout failure
- STRICT, 1, 1: every store is checked; 0: only stores with WIN_LO <= addr <= WIN_HI are checked
- WIN_LO, 0, lower bound of the checked window (STRICT=0)
- WIN_HI, 'hFC, upper bound of the checked window (STRICT=0)

Ports:
- clk  in  1  system clock, all state on the rising edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write one expected entry (honoured only in IDLE)
- cfg_idx  in  IDX_W  table index for cfg_we
- cfg_addr  in  ADDR_W  expected store address
- cfg_data  in  DATA_W  expected store data
- cfg_count_we  in  1  load expected-entry count (IDLE only)
- cfg_count  in  IDX_W+1  number of expected stores, 0..DEPTH
- start  in  1  begin a run (IDLE, PASS or FAIL)
- write_enable  in  1  processor store strobe
- address_to_mem  in  ADDR_W  store address
- data_to_mem  in  DATA_W  store data
- busy  out  1  state==RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state==PASS
- fail  out  1  state==FAIL
- timed_out  out  1  failure was caused by timeout
- match_count  out  IDX_W+1  stores matched so far
- cycle_count  out  CNT_W  RUN cycles elapsed
- err_index  out  IDX_W  table index of the first mismatch
- err_addr  out  ADDR_W  offending store address
- err_data  out  DATA_W  offending store data

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all outputs 0, stored count=0. The table RAM is not cleared; it is irrelevant while count=0. Reset mid-RUN aborts the run and returns to IDLE on the next edge.
- Configuration:
  - cfg_we and cfg_count_we act only in IDLE and are ignored elsewhere.
  - A cfg_count value greater than DEPTH is clamped to DEPTH.
- FSM, states IDLE / RUN / PASS / FAIL:
  - IDLE --start--> RUN. Exception: if count==0, start goes directly to PASS.
  - RUN: cycle_count increments every cycle, saturating at all-ones.
  - A store is "checked" when write_enable=1 and (STRICT=1 or the address is inside the window). Unchecked stores are ignored.
  - Checked store equal to table[match_count] (address and data both equal): match_count increments. If the new match_count equals count, the next state is PASS.
  - Checked store not equal: next state is FAIL. err_index=match_count, err_addr/err_data capture the store, timed_out=0.
  - No deciding store and cycle_count==TIMEOUT-1: next state is FAIL, timed_out=1, err_index=match_count, err_addr/err_data=0.
  - The final matching store on the timeout cycle wins: the result is PASS.
  - PASS / FAIL: all counters and error registers hold and bus activity is ignored. start re-enters RUN, clearing match_count, cycle_count, timed_out and the err_* registers; table and count are kept.
  - start while in RUN is ignored.
- Timing: the verdict is registered. done/pass/fail assert in the cycle after the clock edge that samples the deciding store or timeout.
- Comparison is full-width equality. No byte masking.

Test Plan:
1. count=3, table {(0x10,0xA),(0x14,0xB),(0x18,0xC)}, start, stores issued in order with idle gaps -> pass=1 one cycle after the 3rd store, match_count=3, fail=0.
2. Same table, 2nd store (0x14,0xBB) -> fail=1, err_index=1, err_addr=0x14, err_data=0xBB, timed_out=0, match_count=1; later stores leave all outputs unchanged.
3. TIMEOUT=20, count=2, only one matching store -> fail=1 and timed_out=1 one cycle after cycle_count reaches 19; match_count=1. Repeat with the final store landing on cycle 19 -> pass=1.
4. STRICT=0, window 0x00..0xFC, store to 0x200 between expected stores -> ignored, pass=1. Same stimulus with STRICT=1 -> fail=1, err_addr=0x200.
5. count=0, start -> pass=1 on the next cycle. cfg_we during RUN does not alter the table: verify by rerunning with start and getting the original result.
6. Assert reset mid-RUN after 1 match -> next cycle busy=0, match_count=0, cycle_count=0. count reads back 0: start gives an immediate pass.
